// File: rtl/snitch_icache_tag_ctrl.sv
// Icache tag store: one 1-cycle single-port SRAM per way, registered hit compare, flush sweep.
// Optional parity protection with scrub-on-error is enabled by defining SNITCH_ICACHE_TAG_PARITY_EN.
module snitch_icache_tag_ctrl #(
   parameter int unsigned SET_COUNT  = 2,
   parameter int unsigned LINE_COUNT = 128,
   parameter int unsigned TAG_WIDTH  = 37,
   parameter type         sram_cfg_t = logic,
   localparam int unsigned IdxW = $clog2(LINE_COUNT),
   localparam int unsigned WayW = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  sram_cfg_t            sram_cfg_i,
   input  logic                 flush_req_i,
   output logic                 flush_busy_o,
   input  logic                 lkp_valid_i,
   output logic                 lkp_ready_o,
   input  logic [IdxW-1:0]      lkp_idx_i,
   input  logic [TAG_WIDTH-1:0] lkp_tag_i,
   output logic                 rsp_valid_o,
   output logic                 rsp_hit_o,
   output logic [WayW-1:0]      rsp_way_o,
   output logic                 rsp_perr_o,
   input  logic                 wr_valid_i,
   output logic                 wr_ready_o,
   input  logic [IdxW-1:0]      wr_idx_i,
   input  logic [WayW-1:0]      wr_way_i,
   input  logic [TAG_WIDTH-1:0] wr_tag_i
);

`ifdef SNITCH_ICACHE_TAG_PARITY_EN
   localparam bit ParEn = 1'b1;
`else
   localparam bit ParEn = 1'b0;
`endif

   localparam int unsigned EntW = TAG_WIDTH + 2;

   typedef enum logic [1:0] {FLUSH, IDLE, SCRUB} state_e;

   state_e                          state_q, state_d;
   logic [IdxW-1:0]                 cnt_q, cnt_d;
   logic                            rst_q;
   logic [2:1]                      vld_pipe;
   logic [TAG_WIDTH-1:0]            tag_q;
   logic [IdxW-1:0]                 idx_q, scrub_idx_q;
   logic [SET_COUNT-1:0]            scrub_mask_q;
   logic                            hit_q, perr_q;
   logic [WayW-1:0]                 way_q;

   logic [SET_COUNT-1:0]            sram_en;
   logic                            sram_we;
   logic [IdxW-1:0]                 sram_addr;
   logic [EntW-1:0]                 sram_wdata;
   logic [SET_COUNT-1:0][EntW-1:0]  rdata;
   logic                            lkp_acc;

   logic [SET_COUNT-1:0]            hit_mask, perr_mask;
   logic [WayW-1:0]                 hit_way;
   logic                            cmp_perr;
   logic                            cfg_unused;

   // The SRAM config only matters for real macros; the behavioural array ignores it.
   assign cfg_unused = ^sram_cfg_i;

   for (genvar w = 0; w < SET_COUNT; w++) begin : g_way
      logic [EntW-1:0] mem [LINE_COUNT];
      logic [EntW-1:0] rdata_q;
      always_ff @(posedge clk_i) begin
         if (sram_en[w]) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         rdata_q        <= mem[sram_addr];
         end
      end
      assign rdata[w] = rdata_q;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sram_en     = '0;
      sram_we     = 1'b0;
      sram_addr   = lkp_idx_i;
      sram_wdata  = '0;
      lkp_ready_o = 1'b0;
      wr_ready_o  = 1'b0;
      lkp_acc     = 1'b0;
      case (state_q)
         FLUSH: begin
            // rst_q holds the sweep for one cycle so line k is cleared k+1 cycles after reset.
            if (flush_req_i) begin
               cnt_d = '0;
            end else if (!rst_q) begin
               sram_en   = '1;
               sram_we   = 1'b1;
               sram_addr = cnt_q;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == IdxW'(LINE_COUNT - 1)) state_d = IDLE;
            end
         end
         IDLE: begin
            if (flush_req_i) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end else begin
               wr_ready_o  = 1'b1;
               lkp_ready_o = !wr_valid_i;
               if (wr_valid_i) begin
                  for (int w = 0; w < SET_COUNT; w++) sram_en[w] = (wr_way_i == WayW'(w));
                  sram_we    = 1'b1;
                  sram_addr  = wr_idx_i;
                  sram_wdata = {ParEn & ~(^wr_tag_i), 1'b1, wr_tag_i};
               end else if (lkp_valid_i) begin
                  sram_en = '1;
                  lkp_acc = 1'b1;
               end
               if (cmp_perr) state_d = SCRUB;
            end
         end
         SCRUB: begin
            sram_en   = scrub_mask_q;
            sram_we   = 1'b1;
            sram_addr = scrub_idx_q;
            if (flush_req_i) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end else if (!cmp_perr) begin
               state_d = IDLE;
            end
         end
         default: state_d = FLUSH;
      endcase
   end

   always_comb begin
      hit_way = '0;
      for (int w = 0; w < SET_COUNT; w++) begin
         perr_mask[w] = ParEn && (rdata[w][EntW-1] != ^rdata[w][TAG_WIDTH:0]);
         hit_mask[w]  = rdata[w][TAG_WIDTH] && (rdata[w][TAG_WIDTH-1:0] == tag_q) && !perr_mask[w];
      end
      for (int w = SET_COUNT - 1; w >= 0; w--) begin
         if (hit_mask[w]) hit_way = WayW'(w);
      end
   end

   assign cmp_perr = vld_pipe[1] && (|perr_mask);

   always_ff @(posedge clk_i) begin
      rst_q <= rst_i;
      if (lkp_acc) begin
         tag_q <= lkp_tag_i;
         idx_q <= lkp_idx_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= FLUSH;
         cnt_q        <= '0;
         vld_pipe     <= '0;
         hit_q        <= 1'b0;
         way_q        <= '0;
         perr_q       <= 1'b0;
         scrub_mask_q <= '0;
         scrub_idx_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         vld_pipe     <= {vld_pipe[1], lkp_acc};
         hit_q        <= vld_pipe[1] && (|hit_mask);
         way_q        <= (vld_pipe[1] && (|hit_mask)) ? hit_way : '0;
         perr_q       <= cmp_perr;
         scrub_mask_q <= cmp_perr ? perr_mask : '0;
         scrub_idx_q  <= idx_q;
      end
   end

   assign flush_busy_o = (state_q == FLUSH);
   assign rsp_valid_o  = vld_pipe[2];
   assign rsp_hit_o    = hit_q;
   assign rsp_way_o    = way_q;
   assign rsp_perr_o   = ParEn & perr_q;

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// Scoreboard bench for snitch_icache_tag_ctrl: directed cases plus randomized write/lookup/flush
// traffic checked against an array model of the tag store.
module tb_snitch_icache_tag_ctrl;
   localparam int SETS  = 2;
   localparam int LINES = 128;
   localparam int TW    = 37;
   localparam int IDXW  = 7;
   localparam int WAYW  = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            sram_cfg;
   logic            flush_req, flush_busy;
   logic            lkp_valid, lkp_ready;
   logic [IDXW-1:0] lkp_idx;
   logic [TW-1:0]   lkp_tag;
   logic            rsp_valid, rsp_hit, rsp_perr;
   logic [WAYW-1:0] rsp_way;
   logic            wr_valid, wr_ready;
   logic [IDXW-1:0] wr_idx;
   logic [WAYW-1:0] wr_way;
   logic [TW-1:0]   wr_tag;

   snitch_icache_tag_ctrl #(.SET_COUNT(SETS), .LINE_COUNT(LINES), .TAG_WIDTH(TW)) dut (
      .clk_i(clk), .rst_i(rst), .sram_cfg_i(sram_cfg),
      .flush_req_i(flush_req), .flush_busy_o(flush_busy),
      .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready), .lkp_idx_i(lkp_idx), .lkp_tag_i(lkp_tag),
      .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit), .rsp_way_o(rsp_way), .rsp_perr_o(rsp_perr),
      .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_idx_i(wr_idx), .wr_way_i(wr_way),
      .wr_tag_i(wr_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit hit;
      int way;
      bit perr;
      int cyc;
   } exp_t;

   exp_t          q[$];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   bit            mval[SETS][LINES];
   logic [TW-1:0] mtag[SETS][LINES];
   bit            mcor[SETS][LINES];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void model_clear();
      for (int w = 0; w < SETS; w++)
         for (int i = 0; i < LINES; i++) begin
            mval[w][i] = 0;
            mcor[w][i] = 0;
         end
   endfunction

   // Hit = lowest-numbered way holding a valid uncorrupted copy of the tag.
   function automatic exp_t ref_lookup(int idx, logic [TW-1:0] tag);
      exp_t e;
      e.hit = 0; e.way = 0; e.perr = 0; e.cyc = 0;
      for (int w = 0; w < SETS; w++) begin
         if (mcor[w][idx]) e.perr = 1;
         else if (!e.hit && mval[w][idx] && mtag[w][idx] == tag) begin
            e.hit = 1;
            e.way = w;
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_latency", cyc - e.cyc, 2);
            chk("rsp_hit", rsp_hit, e.hit);
            chk("rsp_way", rsp_way, e.way);
            chk("rsp_perr", rsp_perr, e.perr);
         end
      end
   end

   // One cycle: observe handshakes before the edge, update the model at the edge.
   task automatic tick(output bit wa, output bit la);
      @(negedge clk);
      wa = wr_valid && wr_ready;
      la = lkp_valid && lkp_ready;
      if (la) begin
         exp_t e;
         e = ref_lookup(int'(lkp_idx), lkp_tag);
         e.cyc = cyc;
         q.push_back(e);
      end
      @(posedge clk);
      if (flush_req) model_clear();
      if (wa) begin
         mval[wr_way][wr_idx] = 1;
         mtag[wr_way][wr_idx] = wr_tag;
         mcor[wr_way][wr_idx] = 0;
      end
      #1;
   endtask

   task automatic do_write(int idx, int way, logic [TW-1:0] tag);
      bit wa, la;
      int t = 0;
      wr_valid = 1; wr_idx = IDXW'(idx); wr_way = WAYW'(way); wr_tag = tag;
      do begin tick(wa, la); t++; end while (!wa && t < 300);
      wr_valid = 0;
      chk("wr_accept", wa, 1);
   endtask

   task automatic do_lookup(int idx, logic [TW-1:0] tag);
      bit wa, la;
      int t = 0;
      lkp_valid = 1; lkp_idx = IDXW'(idx); lkp_tag = tag;
      do begin tick(wa, la); t++; end while (!la && t < 300);
      lkp_valid = 0;
      chk("lkp_accept", la, 1);
   endtask

   task automatic count_busy(string name, int exp);
      int  n = 0;
      bit  rdy_bad = 0;
      forever begin
         @(negedge clk);
         if (!flush_busy || n >= 1000) break;
         if (lkp_ready || wr_ready) rdy_bad = 1;
         n++;
      end
      chk(name, n, exp);
      chk({name, "_ready_low"}, rdy_bad, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bit wa, la;
      repeat (4) tick(wa, la);
      chk("queue_drained", q.size(), 0);
   endtask

   initial begin
      bit wa, la;
      rst = 1; sram_cfg = 0; flush_req = 0;
      lkp_valid = 0; lkp_idx = '0; lkp_tag = '0;
      wr_valid = 0; wr_idx = '0; wr_way = '0; wr_tag = '0;
      model_clear();

      repeat (3) begin
         @(negedge clk);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_hit", rsp_hit, 0);
         chk("rst_rsp_way", rsp_way, 0);
         chk("rst_rsp_perr", rsp_perr, 0);
         chk("rst_ready", {lkp_ready, wr_ready}, 0);
         chk("rst_busy", flush_busy, 1);
      end
      @(posedge clk); #1;
      rst = 0;
      count_busy("reset_sweep_cycles", LINES + 1);

      // Empty cache: miss, response two cycles after accept.
      do_lookup(5, 37'h1);
      drain();

      // Single write then hit / near-miss.
      do_write(3, 1, 37'hABC);
      do_lookup(3, 37'hABC);
      do_lookup(3, 37'hABD);
      drain();

      // Same tag in both ways: lowest way wins; back-to-back lookups every cycle.
      do_write(7, 0, 37'h123);
      do_write(7, 1, 37'h123);
      lkp_valid = 1;
      for (int i = 0; i < 4; i++) begin
         lkp_idx = (i % 2 == 0) ? IDXW'(7) : IDXW'(3);
         lkp_tag = (i % 2 == 0) ? 37'h123 : 37'hABC;
         tick(wa, la);
         chk("b2b_accept", la, 1);
      end
      lkp_valid = 0;
      drain();

      // Write and lookup together: write wins, lookup follows and sees the new tag.
      wr_valid = 1; wr_idx = 11; wr_way = 0; wr_tag = 37'h1F00D;
      lkp_valid = 1; lkp_idx = 11; lkp_tag = 37'h1F00D;
      tick(wa, la);
      chk("same_cycle_wr_acc", wa, 1);
      chk("same_cycle_lkp_blocked", la, 0);
      wr_valid = 0;
      tick(wa, la);
      chk("same_cycle_lkp_next", la, 1);
      lkp_valid = 0;
      drain();

      // Fill lines 0..3, flush, all miss afterwards; lookup in flight sees pre-flush contents.
      for (int i = 0; i < 4; i++) do_write(i, i % 2, TW'(64'h100 + i));
      lkp_valid = 1; lkp_idx = 2; lkp_tag = 37'h102;
      tick(wa, la);
      lkp_valid = 0;
      flush_req = 1;
      tick(wa, la);
      flush_req = 0;
      count_busy("flush_sweep_cycles", LINES);
      for (int i = 0; i < 4; i++) do_lookup(i, TW'(64'h100 + i));
      drain();

      // Randomized mix; small index/tag pools keep hits frequent.
      for (int i = 0; i < 600; i++) begin
         int r;
         r = $urandom_range(0, 299);
         flush_req = (r == 0);
         wr_valid  = (r >= 1 && r < 140);
         lkp_valid = (r >= 110);
         wr_idx    = IDXW'($urandom_range(0, 7));
         wr_way    = WAYW'($urandom_range(0, SETS - 1));
         wr_tag    = TW'($urandom_range(0, 3));
         lkp_idx   = IDXW'($urandom_range(0, 7));
         lkp_tag   = TW'($urandom_range(0, 3));
         tick(wa, la);
         if (wr_valid && lkp_valid) chk("rand_lkp_blocked", la, 0);
      end
      flush_req = 0; wr_valid = 0; lkp_valid = 0;
      begin
         int t = 0;
         while (flush_busy && t < 300) begin tick(wa, la); t++; end
      end
      drain();

      // Reset with a lookup in flight: its response is dropped and the sweep restarts.
      do_write(20, 1, 37'h77);
      do_lookup(20, 37'h77);
      rst = 1;
      q.delete();
      repeat (2) begin
         @(negedge clk);
         chk("rst_mid_rsp_valid", rsp_valid, 0);
      end
      @(posedge clk); #1;
      rst = 0;
      model_clear();
      count_busy("rst_mid_sweep_cycles", LINES + 1);
      do_lookup(20, 37'h77);
      drain();

`ifdef SNITCH_ICACHE_TAG_PARITY_EN
      do_write(9, 0, 37'h55);
      repeat (2) tick(wa, la);
      dut.g_way[0].mem[9][TW+1] = ~dut.g_way[0].mem[9][TW+1];
      mcor[0][9] = 1;
      do_lookup(9, 37'h55);
      repeat (4) tick(wa, la);
      mcor[0][9] = 0;
      mval[0][9] = 0;
      do_lookup(9, 37'h55);
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
